text_buffer: RTL



---
 rtl/text_console_pkg.sv | 62 ++++++
 rtl/text_buffer_ram.sv | 54 +++++
 rtl/text_buffer.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/text_console_pkg.sv
// -----------------------------------------------------------------------------
// text_console_pkg
// Shared definitions for the 20x7 text console: geometry, character-id width,
// blank fill code, control codes, the text_buffer FSM state encoding, and the
// helpers that map a (row, col) cursor onto the flat cell index.
// -----------------------------------------------------------------------------
package text_console_pkg;

    localparam int ROW_NUMBER     = 7;
    localparam int COL_NUMBER     = 20;
    localparam int ROW_BIT_LEN    = 4;
    localparam int COL_BIT_LEN    = 6;
    localparam int CHAR_ID_LENGTH = 8;

    localparam int CELL_COUNT = ROW_NUMBER * COL_NUMBER;
    // ceil(log2(140)) = 8
    localparam int ADDR_BITS  = 8;

    localparam logic [CHAR_ID_LENGTH-1:0] BLANK_CHAR = 8'h20;

    localparam logic [CHAR_ID_LENGTH-1:0] CC_BS = 8'h08;
    localparam logic [CHAR_ID_LENGTH-1:0] CC_LF = 8'h0A;
    localparam logic [CHAR_ID_LENGTH-1:0] CC_CR = 8'h0D;
    localparam logic [CHAR_ID_LENGTH-1:0] CC_FF = 8'h0C;

    localparam logic [CHAR_ID_LENGTH-1:0] PRINT_LO = 8'h20;
    localparam logic [CHAR_ID_LENGTH-1:0] PRINT_HI = 8'h7E;

    localparam logic [ROW_BIT_LEN-1:0] ROW_ZERO = 4'd0;
    localparam logic [ROW_BIT_LEN-1:0] ROW_ONE  = 4'd1;
    localparam logic [ROW_BIT_LEN-1:0] LAST_ROW = ROW_BIT_LEN'(ROW_NUMBER - 1);
    localparam logic [COL_BIT_LEN-1:0] COL_ZERO = 6'd0;
    localparam logic [COL_BIT_LEN-1:0] COL_ONE  = 6'd1;
    localparam logic [COL_BIT_LEN-1:0] LAST_COL = COL_BIT_LEN'(COL_NUMBER - 1);

    localparam logic [ADDR_BITS-1:0] ADDR_ZERO  = 8'd0;
    localparam logic [ADDR_BITS-1:0] ADDR_ONE   = 8'd1;
    localparam logic [ADDR_BITS-1:0] COL_STRIDE = ADDR_BITS'(COL_NUMBER);
    localparam logic [ADDR_BITS-1:0] LAST_CELL  = ADDR_BITS'(CELL_COUNT - 1);
    // Last destination index of the row-shift phase of a scroll
    localparam logic [ADDR_BITS-1:0] LAST_COPY  = ADDR_BITS'(COL_NUMBER * (ROW_NUMBER - 1) - 1);

    typedef enum logic [1:0] {
        ST_CLEAR       = 2'd0,
        ST_IDLE        = 2'd1,
        ST_SCROLL_COPY = 2'd2,
        ST_SCROLL_FILL = 2'd3
    } buf_state_t;

    // Flat cell index; the row is widened before the multiply so it cannot truncate
    function automatic logic [ADDR_BITS-1:0] cell_index(
        input logic [ROW_BIT_LEN-1:0] row,
        input logic [COL_BIT_LEN-1:0] col
    );
        return (ADDR_BITS'(row) * COL_STRIDE) + ADDR_BITS'(col);
    endfunction

    function automatic logic is_printable(input logic [CHAR_ID_LENGTH-1:0] code);
        return (code >= PRINT_LO) && (code <= PRINT_HI);
    endfunction

endpackage

// File: rtl/text_buffer_ram.sv
// -----------------------------------------------------------------------------
// text_buffer_ram
// 140-cell character store with one synchronous write port and two
// asynchronous read ports (pixel encoder, internal scroll).
// Ports:
//   clk          : system clock
//   we/waddr/wdata : write enable, flat address, code
//   rin/cin      : encoder row/column; charout is blank when out of range
//   scroll_addr  : flat scroll read address; scroll_data is its content
// -----------------------------------------------------------------------------
module text_buffer_ram
    import text_console_pkg::*;
(
    input  logic                      clk,
    input  logic                      we,
    input  logic [ADDR_BITS-1:0]      waddr,
    input  logic [CHAR_ID_LENGTH-1:0] wdata,
    input  logic [ROW_BIT_LEN-1:0]    rin,
    input  logic [COL_BIT_LEN-1:0]    cin,
    output logic [CHAR_ID_LENGTH-1:0] charout,
    input  logic [ADDR_BITS-1:0]      scroll_addr,
    output logic [CHAR_ID_LENGTH-1:0] scroll_data
);

    logic [CHAR_ID_LENGTH-1:0] mem_r [0:CELL_COUNT-1];
    logic [ADDR_BITS-1:0]      enc_addr_s;

    // Single write port; addresses past the last cell are dropped
    always_ff @(posedge clk) begin
        if (we && (waddr <= LAST_CELL)) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Encoder lookup: off-screen coordinates read as blank
    always_comb begin
        enc_addr_s = cell_index(rin, cin);
        if ((rin <= LAST_ROW) && (cin <= LAST_COL)) begin
            charout = mem_r[enc_addr_s];
        end else begin
            charout = BLANK_CHAR;
        end
    end

    // Scroll source lookup
    always_comb begin
        if (scroll_addr <= LAST_CELL) begin
            scroll_data = mem_r[scroll_addr];
        end else begin
            scroll_data = BLANK_CHAR;
        end
    end

endmodule

// File: rtl/text_buffer.sv
// -----------------------------------------------------------------------------
// text_buffer
// Cursor engine and sweep FSM for the 20x7 text console. Accepts one code per
// valid/ready handshake in IDLE; printable codes are stored at the cursor,
// LF/CR/BS/FF move the cursor, and full-screen clear / one-row scroll run as
// 140-cycle sweeps during which char_ready is low.
// Ports:
//   clk, reset              : clock, synchronous active-high reset
//   char_in, char_valid     : incoming code and its valid
//   char_ready              : high only in IDLE
//   rin, cin, charout       : encoder combinational lookup
//   cursor_row, cursor_col  : current cursor position
// -----------------------------------------------------------------------------
module text_buffer
    import text_console_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHAR_ID_LENGTH-1:0] char_in,
    input  logic                      char_valid,
    output logic                      char_ready,
    input  logic [ROW_BIT_LEN-1:0]    rin,
    input  logic [COL_BIT_LEN-1:0]    cin,
    output logic [CHAR_ID_LENGTH-1:0] charout,
    output logic [ROW_BIT_LEN-1:0]    cursor_row,
    output logic [COL_BIT_LEN-1:0]    cursor_col
);

    buf_state_t                state_r;
    buf_state_t                next_state_s;
    logic [ADDR_BITS-1:0]      sweep_r;
    logic [ROW_BIT_LEN-1:0]    cursor_row_r;
    logic [COL_BIT_LEN-1:0]    cursor_col_r;

    logic                      accept_s;
    logic [ROW_BIT_LEN-1:0]    nxt_row_s;
    logic [COL_BIT_LEN-1:0]    nxt_col_s;
    logic                      idle_we_s;
    logic [ADDR_BITS-1:0]      idle_waddr_s;
    logic [CHAR_ID_LENGTH-1:0] idle_wdata_s;
    logic                      scroll_req_s;
    logic                      clear_req_s;

    logic                      we_s;
    logic [ADDR_BITS-1:0]      waddr_s;
    logic [CHAR_ID_LENGTH-1:0] wdata_s;
    logic [ADDR_BITS-1:0]      scroll_addr_s;
    logic [CHAR_ID_LENGTH-1:0] scroll_data_s;

    assign char_ready = (state_r == ST_IDLE);
    assign accept_s   = char_valid && char_ready;
    assign cursor_row = cursor_row_r;
    assign cursor_col = cursor_col_r;

    text_buffer_ram u_ram (
        .clk         (clk),
        .we          (we_s),
        .waddr       (waddr_s),
        .wdata       (wdata_s),
        .rin         (rin),
        .cin         (cin),
        .charout     (charout),
        .scroll_addr (scroll_addr_s),
        .scroll_data (scroll_data_s)
    );

    // Decode the presented code into cursor move, cell write and sweep request
    always_comb begin
        nxt_row_s    = cursor_row_r;
        nxt_col_s    = cursor_col_r;
        idle_we_s    = 1'b0;
        idle_waddr_s = cell_index(cursor_row_r, cursor_col_r);
        idle_wdata_s = char_in;
        scroll_req_s = 1'b0;
        clear_req_s  = 1'b0;
        if (is_printable(char_in)) begin
            idle_we_s = 1'b1;
            if (cursor_col_r == LAST_COL) begin
                nxt_col_s = COL_ZERO;
                if (cursor_row_r == LAST_ROW) begin
                    // Cell is written now; the scroll then lifts it a row
                    scroll_req_s = 1'b1;
                end else begin
                    nxt_row_s = cursor_row_r + ROW_ONE;
                end
            end else begin
                nxt_col_s = cursor_col_r + COL_ONE;
            end
        end else if ((char_in == CC_LF) || (char_in == CC_CR)) begin
            nxt_col_s = COL_ZERO;
            if (cursor_row_r == LAST_ROW) begin
                scroll_req_s = 1'b1;
            end else begin
                nxt_row_s = cursor_row_r + ROW_ONE;
            end
        end else if (char_in == CC_BS) begin
            if (cursor_col_r != COL_ZERO) begin
                nxt_col_s    = cursor_col_r - COL_ONE;
                idle_we_s    = 1'b1;
                idle_waddr_s = cell_index(cursor_row_r, cursor_col_r - COL_ONE);
                idle_wdata_s = BLANK_CHAR;
            end else if (cursor_row_r != ROW_ZERO) begin
                nxt_row_s    = cursor_row_r - ROW_ONE;
                nxt_col_s    = LAST_COL;
                idle_we_s    = 1'b1;
                idle_waddr_s = cell_index(cursor_row_r - ROW_ONE, LAST_COL);
                idle_wdata_s = BLANK_CHAR;
            end else begin
                // Backspace at home position does nothing
                idle_we_s = 1'b0;
            end
        end else if (char_in == CC_FF) begin
            clear_req_s = 1'b1;
            nxt_row_s   = ROW_ZERO;
            nxt_col_s   = COL_ZERO;
        end else begin
            // Unsupported codes are consumed without effect
            idle_we_s = 1'b0;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_CLEAR;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; sweeps end on the last index of their range
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_CLEAR: begin
                if (sweep_r == LAST_CELL) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_CLEAR;
                end
            end
            ST_IDLE: begin
                if (accept_s && clear_req_s) begin
                    next_state_s = ST_CLEAR;
                end else if (accept_s && scroll_req_s) begin
                    next_state_s = ST_SCROLL_COPY;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_SCROLL_COPY: begin
                if (sweep_r == LAST_COPY) begin
                    next_state_s = ST_SCROLL_FILL;
                end else begin
                    next_state_s = ST_SCROLL_COPY;
                end
            end
            ST_SCROLL_FILL: begin
                if (sweep_r == LAST_CELL) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_SCROLL_FILL;
                end
            end
            default: begin
                next_state_s = ST_CLEAR;
            end
        endcase
    end

    // Write-port mux: the sweep owns the port outside IDLE
    always_comb begin
        we_s          = 1'b0;
        waddr_s       = sweep_r;
        wdata_s       = BLANK_CHAR;
        scroll_addr_s = sweep_r + COL_STRIDE;
        case (state_r)
            ST_CLEAR: begin
                we_s = 1'b1;
            end
            ST_IDLE: begin
                we_s    = accept_s && idle_we_s;
                waddr_s = idle_waddr_s;
                wdata_s = idle_wdata_s;
            end
            ST_SCROLL_COPY: begin
                we_s    = 1'b1;
                wdata_s = scroll_data_s;
            end
            ST_SCROLL_FILL: begin
                // Sweep index continues from 120 to 139: the last row
                we_s = 1'b1;
            end
            default: begin
                we_s = 1'b0;
            end
        endcase
    end

    // Sweep counter: one continuous 0..139 run for both clear and scroll
    always_ff @(posedge clk) begin
        if (reset) begin
            sweep_r <= ADDR_ZERO;
        end else if ((state_r == ST_IDLE) || (sweep_r == LAST_CELL)) begin
            sweep_r <= ADDR_ZERO;
        end else begin
            sweep_r <= sweep_r + ADDR_ONE;
        end
    end

    // Cursor register, updated only on an accepted code
    always_ff @(posedge clk) begin
        if (reset) begin
            cursor_row_r <= ROW_ZERO;
            cursor_col_r <= COL_ZERO;
        end else if (accept_s) begin
            cursor_row_r <= nxt_row_s;
            cursor_col_r <= nxt_col_s;
        end else begin
            cursor_row_r <= cursor_row_r;
            cursor_col_r <= cursor_col_r;
        end
    end

endmodule
